// File: rtl/conv_ctrl_pkg.sv
// Shared types and elaboration helpers for the convolution window controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of bits needed to represent value (at least 1).
  function automatic int unsigned width_of(input int unsigned value);
    int unsigned n = 1;
    while ((value >> n) != 0) n++;
    return n;
  endfunction

  // True when the parameter set describes a buildable controller.
  function automatic bit params_ok(input int unsigned img_w, input int unsigned img_h,
                                   input int unsigned kernel, input int unsigned stride,
                                   input int unsigned latency, input int unsigned cnt_w);
    int unsigned max_dim;
    max_dim = (img_w > img_h) ? img_w : img_h;
    return (kernel >= 1) && (kernel <= img_w) && (kernel <= img_h) &&
           (stride >= 1) && (latency >= 1) && (width_of(max_dim) <= cnt_w);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-length shift register that re-times a strobe to the datapath latency.
module valid_delay_line #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned delay_cycles = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] pipe [delay_cycles];

  // Shift one stage per cycle; reset empties the whole pipe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(delay_cycles); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < int'(delay_cycles); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[delay_cycles-1];

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for a KERNEL x KERNEL convolution stage: counts raster beats,
// flags stride-aligned windows, re-times them and drains the pipeline.
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = 28,
  parameter int unsigned IMG_HEIGHT   = 28,
  parameter int unsigned KERNEL       = 5,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned PIPE_LATENCY = 7,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pixel_valid_in,
  output logic             in_ready,
  output logic             shift_en,
  output logic             window_valid,
  output logic             out_valid,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned FL_W = width_of(PIPE_LATENCY);
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_LOAD  = 2'(LOAD);
  localparam logic [1:0] S_FLUSH = 2'(FLUSH);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  if (!params_ok(IMG_WIDTH, IMG_HEIGHT, KERNEL, STRIDE, PIPE_LATENCY, CNT_W)) begin : g_param_check
    $error("conv_window_ctrl: invalid parameter set");
  end

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] col_next, row_next;
  logic [CNT_W-1:0] col_phase, row_phase, col_phase_next, row_phase_next;
  logic [FL_W-1:0]  flush_cnt, flush_next;
  logic             beat;

  assign beat         = pixel_valid_in & in_ready;
  assign shift_en     = beat;
  assign window_valid = beat && (row_cnt >= CNT_W'(KERNEL-1)) && (col_cnt >= CNT_W'(KERNEL-1)) &&
                        (row_phase == '0) && (col_phase == '0);

  // Next-state, counter and phase logic; phases track (cnt - (KERNEL-1)) mod STRIDE.
  always_comb begin
    state_next     = state;
    col_next       = col_cnt;
    row_next       = row_cnt;
    col_phase_next = col_phase;
    row_phase_next = row_phase;
    flush_next     = flush_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_LOAD;
          col_next       = '0;
          row_next       = '0;
          col_phase_next = '0;
          row_phase_next = '0;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (col_cnt == CNT_W'(IMG_WIDTH-1)) begin
            col_next       = '0;
            col_phase_next = '0;
            row_next       = row_cnt + CNT_W'(1);
            if (row_cnt < CNT_W'(KERNEL-1) || row_phase == CNT_W'(STRIDE-1)) row_phase_next = '0;
            else row_phase_next = row_phase + CNT_W'(1);
            if (row_cnt == CNT_W'(IMG_HEIGHT-1)) begin
              state_next = S_FLUSH;
              flush_next = FL_W'(PIPE_LATENCY-1);
            end
          end else begin
            col_next = col_cnt + CNT_W'(1);
            if (col_cnt < CNT_W'(KERNEL-1) || col_phase == CNT_W'(STRIDE-1)) col_phase_next = '0;
            else col_phase_next = col_phase + CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt == '0) state_next = S_DONE;
        else flush_next = flush_cnt - FL_W'(1);
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      col_cnt    <= '0;
      row_cnt    <= '0;
      col_phase  <= '0;
      row_phase  <= '0;
      flush_cnt  <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      col_cnt    <= col_next;
      row_cnt    <= row_next;
      col_phase  <= col_phase_next;
      row_phase  <= row_phase_next;
      flush_cnt  <= flush_next;
      in_ready   <= (state_next == S_LOAD);
      busy       <= (state_next != S_IDLE);
      frame_done <= (state_next == S_DONE);
    end
  end

  valid_delay_line #(
    .DATA_WIDTH  (1),
    .delay_cycles(PIPE_LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .reset(reset),
    .din  (window_valid),
    .dout (out_valid)
  );

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: 6x6 K3 at stride 1 and 2, plus the default 28x28 K5 with throttled input.
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic pv = 1'b0;

  logic a_in_ready, a_shift_en, a_window_valid, a_out_valid, a_busy, a_frame_done;
  logic b_in_ready, b_shift_en, b_window_valid, b_out_valid, b_busy, b_frame_done;
  logic c_in_ready, c_shift_en, c_window_valid, c_out_valid, c_busy, c_frame_done;
  logic [7:0] a_col, a_row, b_col, b_row, c_col, c_row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .KERNEL(3), .STRIDE(1), .PIPE_LATENCY(7), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .pixel_valid_in(pv), .in_ready(a_in_ready),
    .shift_en(a_shift_en), .window_valid(a_window_valid), .out_valid(a_out_valid),
    .col_cnt(a_col), .row_cnt(a_row), .busy(a_busy), .frame_done(a_frame_done));

  conv_window_ctrl #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .KERNEL(3), .STRIDE(2), .PIPE_LATENCY(7), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .start(start), .pixel_valid_in(pv), .in_ready(b_in_ready),
    .shift_en(b_shift_en), .window_valid(b_window_valid), .out_valid(b_out_valid),
    .col_cnt(b_col), .row_cnt(b_row), .busy(b_busy), .frame_done(b_frame_done));

  conv_window_ctrl u_c (
    .clk(clk), .reset(reset), .start(start), .pixel_valid_in(pv), .in_ready(c_in_ready),
    .shift_en(c_shift_en), .window_valid(c_window_valid), .out_valid(c_out_valid),
    .col_cnt(c_col), .row_cnt(c_row), .busy(c_busy), .frame_done(c_frame_done));

  // Event counters sampled on the falling edge; hist bit 6 holds window_valid from 7 cycles ago.
  int unsigned a_beat_n = 0, a_wv_n = 0, a_ov_n = 0, a_fd_n = 0, a_lat_bad = 0;
  logic [6:0] a_hist = '0;
  always @(negedge clk) begin
    a_hist <= {a_hist[5:0], a_window_valid};
    if (a_out_valid !== a_hist[6]) a_lat_bad <= a_lat_bad + 1;
    if (pv && a_in_ready) a_beat_n <= a_beat_n + 1;
    if (a_window_valid) a_wv_n <= a_wv_n + 1;
    if (a_out_valid) a_ov_n <= a_ov_n + 1;
    if (a_frame_done) a_fd_n <= a_fd_n + 1;
  end

  int unsigned b_wv_n = 0, b_ov_n = 0, b_lat_bad = 0;
  logic [6:0] b_hist = '0;
  logic [15:0] b_pos [32];
  always @(negedge clk) begin
    b_hist <= {b_hist[5:0], b_window_valid};
    if (b_out_valid !== b_hist[6]) b_lat_bad <= b_lat_bad + 1;
    if (b_window_valid) begin
      b_pos[b_wv_n[4:0]] <= {b_row, b_col};
      b_wv_n <= b_wv_n + 1;
    end
    if (b_out_valid) b_ov_n <= b_ov_n + 1;
  end

  int unsigned c_beat_n = 0, c_wv_n = 0, c_ov_n = 0, c_fd_n = 0, c_lat_bad = 0, c_shift_bad = 0, c_hold_bad = 0;
  logic [6:0] c_hist = '0;
  logic [7:0] c_prev_col = '0, c_prev_row = '0;
  logic c_prev_beat = 1'b0, c_prev_ir = 1'b0;
  always @(negedge clk) begin
    c_hist <= {c_hist[5:0], c_window_valid};
    if (c_out_valid !== c_hist[6]) c_lat_bad <= c_lat_bad + 1;
    if (c_shift_en !== (pv & c_in_ready)) c_shift_bad <= c_shift_bad + 1;
    if (c_prev_ir && c_in_ready && !c_prev_beat && ({c_row, c_col} !== {c_prev_row, c_prev_col}))
      c_hold_bad <= c_hold_bad + 1;
    c_prev_col  <= c_col;
    c_prev_row  <= c_row;
    c_prev_beat <= pv & c_in_ready;
    c_prev_ir   <= c_in_ready;
    if (pv && c_in_ready) c_beat_n <= c_beat_n + 1;
    if (c_window_valid) c_wv_n <= c_wv_n + 1;
    if (c_out_valid) c_ov_n <= c_ov_n + 1;
    if (c_frame_done) c_fd_n <= c_fd_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pv = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if ({a_in_ready, a_busy, a_frame_done, a_out_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {a_in_ready, a_busy, a_frame_done, a_out_valid});
    end
    checks++; if ({a_row, a_col} !== 16'h0000) begin
      errors++; $display("FAIL reset_counters got row %0d col %0d exp 0 0", a_row, a_col);
    end
    checks++; if ({c_busy, c_in_ready, c_out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_c_flags got %b exp 000", {c_busy, c_in_ready, c_out_valid});
    end
    reset = 1'b1;
  endtask

  task automatic test_idle_hold();
    pv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      checks++; if ({a_in_ready, a_shift_en, a_window_valid, a_busy} !== 4'b0000 || {a_row, a_col} !== 16'h0) begin
        errors++; $display("FAIL idle_hold got ir/se/wv/busy %b row %0d col %0d exp 0000 0 0",
                           {a_in_ready, a_shift_en, a_window_valid, a_busy}, a_row, a_col);
      end
    end
    pv = 1'b0;
  endtask

  // One 6x6 frame with continuous pixels; start==cycle 0, beats in cycles 1..36.
  task automatic run_6x6(input bit extra_starts);
    int unsigned s_beat = a_beat_n, s_wv = a_wv_n, s_ov = a_ov_n, s_fd = a_fd_n, s_lat = a_lat_bad;
    int unsigned s_bwv = b_wv_n, s_bov = b_ov_n, s_blat = b_lat_bad;
    int unsigned fd_bad = 0;
    logic [15:0] exp_pos;
    tick(); start = 1'b1; pv = 1'b1; #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL frame_idle_busy got %b exp 0", a_busy); end
    for (int k = 1; k <= 50; k++) begin
      tick();
      start = extra_starts && (k == 10 || k == 40 || k == 44);
      #1;
      if (k == 1) begin
        checks++; if (a_in_ready !== 1'b1 || {a_row, a_col} !== 16'h0) begin
          errors++; $display("FAIL first_beat got ir %b row %0d col %0d exp 1 0 0", a_in_ready, a_row, a_col);
        end
      end
      if (k == 14) begin
        checks++; if (a_window_valid !== 1'b0) begin errors++; $display("FAIL early_window got %b exp 0", a_window_valid); end
      end
      if (k == 15 || k == 36) begin
        checks++; if (a_window_valid !== 1'b1) begin
          errors++; $display("FAIL window_at_cycle_%0d got %b exp 1 (row %0d col %0d)", k, a_window_valid, a_row, a_col);
        end
      end
      if (k == 22) begin
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b exp 1", a_out_valid); end
      end
      if (k >= 37 && k <= 43) begin
        checks++; if ({a_in_ready, a_shift_en, a_busy} !== 3'b001 || {a_row, a_col} !== {8'd6, 8'd0}) begin
          errors++; $display("FAIL flush_hold k=%0d got ir/se/busy %b row %0d col %0d exp 001 6 0",
                             k, {a_in_ready, a_shift_en, a_busy}, a_row, a_col);
        end
      end
      if (k == 44) begin
        checks++; if (a_frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_time got %b exp 1", a_frame_done); end
      end else if (a_frame_done !== 1'b0) fd_bad++;
      if (k == 45 || k == 46) begin
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_after_done k=%0d got %b exp 0", k, a_busy); end
      end
    end
    start = 1'b0; pv = 1'b0;
    checks++; if (fd_bad != 0) begin errors++; $display("FAIL stray_frame_done got %0d exp 0", fd_bad); end
    checks++; if (a_beat_n - s_beat != 36) begin errors++; $display("FAIL beats got %0d exp 36", a_beat_n - s_beat); end
    checks++; if (a_wv_n - s_wv != 16) begin errors++; $display("FAIL windows_s1 got %0d exp 16", a_wv_n - s_wv); end
    checks++; if (a_ov_n - s_ov != 16) begin errors++; $display("FAIL out_valid_s1 got %0d exp 16", a_ov_n - s_ov); end
    checks++; if (a_lat_bad != s_lat) begin errors++; $display("FAIL latency_s1 got %0d bad cycles exp 0", a_lat_bad - s_lat); end
    checks++; if (a_fd_n - s_fd != 1) begin errors++; $display("FAIL frame_done_count got %0d exp 1", a_fd_n - s_fd); end
    checks++; if (b_wv_n - s_bwv != 4) begin errors++; $display("FAIL windows_s2 got %0d exp 4", b_wv_n - s_bwv); end
    checks++; if (b_ov_n - s_bov != 4) begin errors++; $display("FAIL out_valid_s2 got %0d exp 4", b_ov_n - s_bov); end
    checks++; if (b_lat_bad != s_blat) begin errors++; $display("FAIL latency_s2 got %0d bad cycles exp 0", b_lat_bad - s_blat); end
    for (int i = 0; i < 4; i++) begin
      exp_pos = {8'(2 + 2 * (i / 2)), 8'(2 + 2 * (i % 2))};
      checks++; if (b_pos[5'(s_bwv + i)] !== exp_pos) begin
        errors++; $display("FAIL s2_pos_%0d got row %0d col %0d exp row %0d col %0d", i,
                           b_pos[5'(s_bwv + i)][15:8], b_pos[5'(s_bwv + i)][7:0], exp_pos[15:8], exp_pos[7:0]);
      end
    end
  endtask

  task automatic test_frame();
    run_6x6(1'b0);
  endtask

  task automatic test_start_ignored();
    run_6x6(1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int unsigned ov_seen = 0, fd_seen = 0, busy_seen = 0;
    tick(); start = 1'b1; pv = 1'b1; #1;
    for (int k = 1; k <= 21; k++) begin
      tick(); start = 1'b0;
      if (k == 21) reset = 1'b0;
    end
    tick(); reset = 1'b1; #1;
    checks++; if ({a_busy, a_in_ready, a_out_valid} !== 3'b000 || {a_row, a_col} !== 16'h0) begin
      errors++; $display("FAIL mid_reset_state got busy/ir/ov %b row %0d col %0d exp 000 0 0",
                         {a_busy, a_in_ready, a_out_valid}, a_row, a_col);
    end
    for (int k = 0; k < 20; k++) begin
      tick(); #1;
      if (a_out_valid) ov_seen++;
      if (a_frame_done) fd_seen++;
      if (a_busy) busy_seen++;
    end
    pv = 1'b0;
    checks++; if (ov_seen != 0) begin errors++; $display("FAIL residual_out_valid got %0d exp 0", ov_seen); end
    checks++; if (fd_seen != 0 || busy_seen != 0) begin
      errors++; $display("FAIL aborted_frame got frame_done %0d busy %0d exp 0 0", fd_seen, busy_seen);
    end
    run_6x6(1'b0);
  endtask

  task automatic test_throttle();
    int unsigned s_beat, s_wv, s_ov, s_fd, s_lat, s_sh, s_hold;
    bit done = 1'b0;
    tick(); reset = 1'b0; pv = 1'b0; start = 1'b0;
    tick(); reset = 1'b1; #1;
    s_beat = c_beat_n; s_wv = c_wv_n; s_ov = c_ov_n; s_fd = c_fd_n;
    s_lat = c_lat_bad; s_sh = c_shift_bad; s_hold = c_hold_bad;
    tick(); start = 1'b1; #1;
    for (int k = 1; k <= 2000 && !done; k++) begin
      tick(); start = 1'b0; pv = ((k % 2) == 1); #1;
      if (c_fd_n != s_fd) done = 1'b1;
    end
    pv = 1'b0;
    repeat (3) tick();
    checks++; if (!done) begin errors++; $display("FAIL throttle_timeout got no frame_done exp frame_done within 2000 cycles"); end
    checks++; if (c_beat_n - s_beat != 784) begin errors++; $display("FAIL throttle_beats got %0d exp 784", c_beat_n - s_beat); end
    checks++; if (c_wv_n - s_wv != 576) begin errors++; $display("FAIL throttle_windows got %0d exp 576", c_wv_n - s_wv); end
    checks++; if (c_ov_n - s_ov != 576) begin errors++; $display("FAIL throttle_out_valid got %0d exp 576", c_ov_n - s_ov); end
    checks++; if (c_lat_bad != s_lat) begin errors++; $display("FAIL throttle_latency got %0d bad cycles exp 0", c_lat_bad - s_lat); end
    checks++; if (c_shift_bad != s_sh) begin errors++; $display("FAIL throttle_shift_en got %0d bad cycles exp 0", c_shift_bad - s_sh); end
    checks++; if (c_hold_bad != s_hold) begin errors++; $display("FAIL throttle_hold got %0d bad cycles exp 0", c_hold_bad - s_hold); end
    checks++; if (c_fd_n - s_fd != 1) begin errors++; $display("FAIL throttle_frame_done got %0d exp 1", c_fd_n - s_fd); end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_frame();
    test_start_ignored();
    test_reset_mid_frame();
    test_throttle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
